// File: rtl/noc_req_arbiter.sv
// Round-robin arbiter feeding a one-entry NoC request slot. It tracks one
// outstanding request per requester, routes acks back and owns the memory lock.
module noc_req_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ADDR_W   = 10,
  parameter int OPCODE_W = 2,
  parameter int WIDTH_W  = 3,
  parameter int SRC_ID_W = 4,
  parameter int SRC_BASE = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*WIDTH_W-1:0]  req_width,
  input  logic [N_REQ*OPCODE_W-1:0] req_opcode,
  input  logic [N_REQ-1:0]          req_is_mem,
  input  logic [N_REQ-1:0]          mem_release,
  input  logic                      ser_busy,
  output logic [N_REQ-1:0]          arb_won,
  output logic [N_REQ-1:0]          mem_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_W-1:0]         out_addr,
  output logic [WIDTH_W-1:0]        out_width,
  output logic [OPCODE_W-1:0]       out_opcode,
  output logic                      out_is_mem,
  output logic [SRC_ID_W-1:0]       out_source_id,
  input  logic                      ack_valid,
  input  logic [SRC_ID_W-1:0]       ack_src_id,
  output logic [N_REQ-1:0]          ack
);
  localparam int IDX_W = $clog2(N_REQ);

  logic                out_valid_q;
  logic [ADDR_W-1:0]   out_addr_q;
  logic [WIDTH_W-1:0]  out_width_q;
  logic [OPCODE_W-1:0] out_opcode_q;
  logic                out_is_mem_q;
  logic [SRC_ID_W-1:0] out_src_q;
  logic [N_REQ-1:0]    arb_won_q, won_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic [N_REQ-1:0]    pending_q, pending_d;
  logic                mem_locked_q, mem_locked_d;
  logic [IDX_W-1:0]    mem_owner_q, mem_owner_d;
  logic [IDX_W-1:0]    rr_ptr_q;

  logic [N_REQ-1:0]    mem_ready_c;
  logic [N_REQ-1:0]    eligible;
  logic                found;
  logic                grant;
  logic                lock_set;
  logic                rel_hit;
  logic [IDX_W-1:0]    win;

  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int ofs);
    return IDX_W'((int'(base) + ofs) % N_REQ);
  endfunction

  always_comb begin
    mem_ready_c = '0;
    eligible    = '0;
    ack_d       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      mem_ready_c[i] = !mem_locked_q || (mem_owner_q == IDX_W'(i));
      eligible[i]    = req_valid[i] && !pending_q[i] && !ser_busy &&
                       (!req_is_mem[i] || mem_ready_c[i]);
      ack_d[i]       = ack_valid && (ack_src_id == SRC_ID_W'(SRC_BASE + i));
    end
  end

  // First eligible requester at or after the round-robin pointer wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && eligible[rr_idx(rr_ptr_q, k)]) begin
        found = 1'b1;
        win   = rr_idx(rr_ptr_q, k);
      end
    end
  end

  assign grant = found && (!out_valid_q || out_ready);

  // A release from the owner, including one that just took the lock this edge, wins.
  always_comb begin
    won_d     = '0;
    pending_d = pending_q & ~ack_d;
    rel_hit   = 1'b0;
    if (grant) begin
      won_d[win]     = 1'b1;
      pending_d[win] = 1'b1;
    end
    lock_set = grant && req_is_mem[win] && !mem_locked_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (mem_release[i] &&
          ((mem_locked_q && (mem_owner_q == IDX_W'(i))) || (lock_set && (win == IDX_W'(i)))))
        rel_hit = 1'b1;
    end
    mem_locked_d = (mem_locked_q || lock_set) && !rel_hit;
    mem_owner_d  = lock_set ? win : mem_owner_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_width_q  <= '0;
      out_opcode_q <= '0;
      out_is_mem_q <= 1'b0;
      out_src_q    <= '0;
      arb_won_q    <= '0;
      ack_q        <= '0;
      pending_q    <= '0;
      mem_locked_q <= 1'b0;
      mem_owner_q  <= '0;
      rr_ptr_q     <= '0;
    end else begin
      arb_won_q    <= won_d;
      ack_q        <= ack_d;
      pending_q    <= pending_d;
      mem_locked_q <= mem_locked_d;
      mem_owner_q  <= mem_owner_d;
      if (grant) begin
        out_valid_q  <= 1'b1;
        out_addr_q   <= req_addr[win*ADDR_W +: ADDR_W];
        out_width_q  <= req_width[win*WIDTH_W +: WIDTH_W];
        out_opcode_q <= req_opcode[win*OPCODE_W +: OPCODE_W];
        out_is_mem_q <= req_is_mem[win];
        out_src_q    <= SRC_ID_W'(SRC_BASE + int'(win));
        rr_ptr_q     <= rr_idx(win, 1);
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign arb_won       = arb_won_q;
  assign ack           = ack_q;
  assign mem_ready     = mem_ready_c;
  assign out_valid     = out_valid_q;
  assign out_addr      = out_addr_q;
  assign out_width     = out_width_q;
  assign out_opcode    = out_opcode_q;
  assign out_is_mem    = out_is_mem_q;
  assign out_source_id = out_src_q;

endmodule

// File: tb/tb_noc_req_arbiter.sv
// Scoreboard bench for noc_req_arbiter: a transaction-level model predicts
// grants, acks and slot/lock state; a monitor compares on the falling edge.
module tb_noc_req_arbiter;
  localparam int N = 4, AW = 10, OW = 2, WW = 3, SW = 4, SRC_BASE = 0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0, req_is_mem = '0, mem_release = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*WW-1:0]   req_width = '0;
  logic [N*OW-1:0]   req_opcode = '0;
  logic              ser_busy = 1'b0, out_ready = 1'b1, ack_valid = 1'b0;
  logic [SW-1:0]     ack_src_id = '0;
  logic [N-1:0]      arb_won, mem_ready, ack;
  logic              out_valid, out_is_mem;
  logic [AW-1:0]     out_addr;
  logic [WW-1:0]     out_width;
  logic [OW-1:0]     out_opcode;
  logic [SW-1:0]     out_source_id;

  noc_req_arbiter #(.N_REQ(N), .ADDR_W(AW), .OPCODE_W(OW), .WIDTH_W(WW),
                    .SRC_ID_W(SW), .SRC_BASE(SRC_BASE)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_width(req_width), .req_opcode(req_opcode), .req_is_mem(req_is_mem),
    .mem_release(mem_release), .ser_busy(ser_busy), .arb_won(arb_won),
    .mem_ready(mem_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_width(out_width), .out_opcode(out_opcode),
    .out_is_mem(out_is_mem), .out_source_id(out_source_id), .ack_valid(ack_valid),
    .ack_src_id(ack_src_id), .ack(ack));

  always #5 clk = ~clk;

  typedef struct {
    bit            ov;
    logic [AW-1:0] a;
    logic [WW-1:0] w;
    logic [OW-1:0] op;
    bit            m;
    logic [SW-1:0] src;
    logic [N-1:0]  mr;
  } st_t;

  st_t sq[$];
  int  gq[$];
  int  aq[$];
  int  errors = 0, checks = 0;

  bit  pend[N];
  bit  locked;
  int  owner, ptr;
  st_t slot;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    locked = 1'b0;
    owner  = 0;
    ptr    = 0;
    slot   = '{default: 0};
    slot.mr = '1;
    sq.delete();
    gq.delete();
    aq.delete();
  endtask

  // Reference model: one transaction decision per rising edge.
  always @(posedge clk) begin : model
    int w, c, was_owner;
    bit was_locked;
    if (rst_n) begin
      w = -1;
      if (!ser_busy && (!slot.ov || out_ready)) begin
        for (int k = 0; k < N; k++) begin
          c = (ptr + k) % N;
          if (w < 0 && req_valid[c] && !pend[c] && (!req_is_mem[c] || !locked || owner == c))
            w = c;
        end
      end
      if (ack_valid && int'(ack_src_id) - SRC_BASE >= 0 && int'(ack_src_id) - SRC_BASE < N) begin
        pend[int'(ack_src_id) - SRC_BASE] = 1'b0;
        aq.push_back(int'(ack_src_id) - SRC_BASE);
      end
      was_locked = locked;
      was_owner  = owner;
      if (was_locked && mem_release[was_owner]) locked = 1'b0;
      if (w >= 0) begin
        slot.ov  = 1'b1;
        slot.a   = req_addr[w*AW +: AW];
        slot.w   = req_width[w*WW +: WW];
        slot.op  = req_opcode[w*OW +: OW];
        slot.m   = req_is_mem[w];
        slot.src = SW'(SRC_BASE + w);
        pend[w]  = 1'b1;
        ptr      = (w + 1) % N;
        gq.push_back(w);
        if (req_is_mem[w] && !was_locked) begin
          owner  = w;
          locked = !mem_release[w];
        end
      end else if (out_ready) begin
        slot.ov = 1'b0;
      end
      for (int i = 0; i < N; i++) slot.mr[i] = !locked || (owner == i);
      sq.push_back(slot);
    end
  end

  always @(negedge clk) begin : monitor
    st_t s;
    logic [N-1:0] oh;
    int w;
    if (rst_n) begin
      if (sq.size() > 0) begin
        s = sq.pop_front();
        check("out_valid", 32'(out_valid), 32'(s.ov));
        check("mem_ready", 32'(mem_ready), 32'(s.mr));
        if (s.ov) begin
          check("out_addr", 32'(out_addr), 32'(s.a));
          check("out_width", 32'(out_width), 32'(s.w));
          check("out_opcode", 32'(out_opcode), 32'(s.op));
          check("out_is_mem", 32'(out_is_mem), 32'(s.m));
          check("out_source_id", 32'(out_source_id), 32'(s.src));
        end
      end
      oh = '0;
      if (gq.size() > 0) begin
        w = gq.pop_front();
        oh[w] = 1'b1;
      end
      check("arb_won", 32'(arb_won), 32'(oh));
      oh = '0;
      if (aq.size() > 0) begin
        w = aq.pop_front();
        oh[w] = 1'b1;
      end
      check("ack", 32'(ack), 32'(oh));
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
    ack_valid   = 1'b0;
    ack_src_id  = '0;
    mem_release = '0;
  endtask

  task automatic rand_fields();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]   = AW'($urandom());
      req_width[i*WW +: WW]  = WW'($urandom());
      req_opcode[i*OW +: OW] = OW'($urandom());
    end
  endtask

  task automatic auto_ack(input int pct);
    int cand[$];
    for (int i = 0; i < N; i++) if (pend[i]) cand.push_back(i);
    if (cand.size() > 0 && int'($urandom_range(99)) < pct) begin
      ack_valid  = 1'b1;
      ack_src_id = SW'(SRC_BASE + cand[$urandom_range(cand.size() - 1)]);
    end
  endtask

  task automatic drain();
    repeat (10) begin
      next();
      req_valid = '0;
      ser_busy  = 1'b0;
      out_ready = 1'b1;
      auto_ack(100);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_arb_won"}, 32'(arb_won), 32'd0);
    check({tag, "_ack"}, 32'(ack), 32'd0);
    check({tag, "_mem_ready"}, 32'(mem_ready), 32'hF);
    check({tag, "_out_addr"}, 32'(out_addr), 32'd0);
    check({tag, "_out_fields"}, {out_width, out_opcode, out_is_mem}, 32'd0);
    check({tag, "_out_source_id"}, 32'(out_source_id), 32'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) next();
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // All requesters non-mem, steady acks: rotating grants.
    req_valid = '1;
    req_is_mem = '0;
    out_ready = 1'b1;
    repeat (16) begin
      next();
      rand_fields();
      auto_ack(50);
    end
    drain();

    // Requester 2 holds valid without ack, then is acked.
    next();
    req_valid = 4'b0100;
    rand_fields();
    repeat (4) next();
    next();
    ack_valid = 1'b1;
    ack_src_id = 4'd2;
    repeat (4) next();
    drain();

    // Slot stall, then drain with simultaneous new grant.
    next();
    req_valid = '1;
    out_ready = 1'b0;
    repeat (4) begin
      next();
      rand_fields();
    end
    next();
    out_ready = 1'b1;
    repeat (3) next();
    drain();

    // Memory lock ownership and release rules.
    next();
    req_valid = 4'b0010;
    req_is_mem = 4'b0010;
    rand_fields();
    next();
    req_valid = 4'b1000;
    req_is_mem = 4'b1000;
    repeat (2) next();
    next();
    mem_release = 4'b1000;
    repeat (2) next();
    mem_release = 4'b0010;
    repeat (3) next();
    mem_release = 4'b1000;
    drain();
    next();
    req_valid = 4'b0100;
    req_is_mem = 4'b0100;
    mem_release = 4'b0100;
    next();
    req_valid = 4'b0001;
    req_is_mem = 4'b0001;
    mem_release = 4'b1000;
    repeat (2) next();
    mem_release = 4'b0001;
    drain();

    // Serializer busy blocks grants; acks still route, out-of-range id ignored.
    next();
    req_valid = 4'b0011;
    req_is_mem = '0;
    repeat (3) next();
    ser_busy = 1'b1;
    req_valid = '1;
    next();
    auto_ack(100);
    next();
    ack_valid = 1'b1;
    ack_src_id = 4'd9;
    repeat (2) next();
    ser_busy = 1'b0;
    repeat (3) next();
    drain();

    // Randomized traffic.
    repeat (1500) begin
      int r;
      next();
      req_valid  = N'($urandom());
      req_is_mem = N'($urandom()) & N'($urandom());
      rand_fields();
      out_ready  = ($urandom_range(3) != 0);
      ser_busy   = ($urandom_range(9) == 0);
      if ($urandom_range(9) == 0) mem_release[$urandom_range(N - 1)] = 1'b1;
      r = int'($urandom_range(9));
      if (r < 4) auto_ack(100);
      else if (r == 4) begin
        ack_valid  = 1'b1;
        ack_src_id = SW'($urandom_range(15, 4));
      end
    end
    drain();
    next();
    mem_release = '1;
    drain();

    // Asynchronous reset with a full slot, lock held and requests pending.
    next();
    req_valid = 4'b0001;
    req_is_mem = 4'b0001;
    rand_fields();
    next();
    req_valid = 4'b0110;
    req_is_mem = '0;
    next();
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("async_reset");
    next();
    next();
    rst_n = 1'b1;
    req_valid = 4'b0110;
    out_ready = 1'b1;
    repeat (6) begin
      next();
      auto_ack(50);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
